// File: rtl/pwm_pkg.sv
// pwm_gen shared constants
// Mode encoding and default width
package pwm_pkg;

  localparam int CNT_W_DEF = 16;

  localparam logic [1:0] MODE_LEFT   = 2'b00;
  localparam logic [1:0] MODE_RIGHT  = 2'b01;
  localparam logic [1:0] MODE_WINDOW = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

endpackage

// File: rtl/pwm_if.sv
// pwm_gen signal bundle
// Master drives counter/config, slave returns PWM
interface pwm_if #(
  parameter int CNT_W = 16
);

  logic [CNT_W-1:0] count_val;
  logic [CNT_W-1:0] period;
  logic             upnotdown;
  logic             pwm_en;
  logic [1:0]       functions;
  logic [CNT_W-1:0] compare1;
  logic [CNT_W-1:0] compare2;
  logic             pwm_out;
  logic             period_evt;

  modport master (
    output count_val,
    output period,
    output upnotdown,
    output pwm_en,
    output functions,
    output compare1,
    output compare2,
    input  pwm_out,
    input  period_evt
  );

  modport slave (
    input  count_val,
    input  period,
    input  upnotdown,
    input  pwm_en,
    input  functions,
    input  compare1,
    input  compare2,
    output pwm_out,
    output period_evt
  );

endinterface

// File: rtl/pwm_shadow_regs.sv
// Boundary detect, shadow compare set, period event
// Outputs are bypassed so a boundary cycle sees new values
module pwm_shadow_regs
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] i_count_val,
  input  logic [CNT_W-1:0] i_period,
  input  logic             i_upnotdown,
  input  logic             i_pwm_en,
  input  logic [1:0]       i_functions,
  input  logic [CNT_W-1:0] i_compare1,
  input  logic [CNT_W-1:0] i_compare2,
  output logic [CNT_W-1:0] o_cmp1,
  output logic [CNT_W-1:0] o_cmp2,
  output logic [1:0]       o_mode,
  output logic             o_period_evt
);

  logic [CNT_W-1:0] r_prev;
  logic [CNT_W-1:0] r_cmp1_s;
  logic [CNT_W-1:0] r_cmp2_s;
  logic [CNT_W-1:0] r_per_s;
  logic [1:0]       r_mode_s;
  logic             r_evt;

  logic w_tick;
  logic w_edge;
  logic w_bnd;
  logic w_load;

  assign w_tick = (i_count_val != r_prev);
  assign w_edge = i_upnotdown ?
                  (i_count_val == '0) :
                  (i_count_val == r_per_s);
  assign w_bnd  = w_tick && w_edge;
  assign w_load = !i_pwm_en || w_bnd;

  assign o_cmp1 = w_load ? i_compare1 : r_cmp1_s;
  assign o_cmp2 = w_load ? i_compare2 : r_cmp2_s;
  assign o_mode = w_load ? i_functions : r_mode_s;
  assign o_period_evt = r_evt;

  // Track last count for change detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= '0;
    else        r_prev <= i_count_val;
  end

  // Shadows: transparent when disabled, else load at boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmp1_s <= '0;
      r_cmp2_s <= '0;
      r_per_s  <= '0;
      r_mode_s <= '0;
    end else if (w_load) begin
      r_cmp1_s <= i_compare1;
      r_cmp2_s <= i_compare2;
      r_per_s  <= i_period;
      r_mode_s <= i_functions;
    end
  end

  // One-cycle event after an enabled boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_evt <= 1'b0;
    else        r_evt <= w_bnd && i_pwm_en;
  end

endmodule

// File: rtl/pwm_gen.sv
// PWM generator top
// Compares live count to shadowed compares, one output flop
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int   CNT_W    = CNT_W_DEF,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  pwm_if.slave bus
);

  logic [CNT_W-1:0] w_cmp1;
  logic [CNT_W-1:0] w_cmp2;
  logic [1:0]       w_mode;
  logic             w_evt;
  logic             w_hi;
  logic             r_pwm_out;

  pwm_shadow_regs #(
    .CNT_W(CNT_W)
  ) u_shadow (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_count_val (bus.count_val),
    .i_period    (bus.period),
    .i_upnotdown (bus.upnotdown),
    .i_pwm_en    (bus.pwm_en),
    .i_functions (bus.functions),
    .i_compare1  (bus.compare1),
    .i_compare2  (bus.compare2),
    .o_cmp1      (w_cmp1),
    .o_cmp2      (w_cmp2),
    .o_mode      (w_mode),
    .o_period_evt(w_evt)
  );

  // Mode-dependent compare of live count
  always_comb begin
    w_hi = IDLE_LVL;
    unique case (1'b1)
      (w_mode == MODE_LEFT):
        w_hi = (bus.count_val < w_cmp1);
      (w_mode == MODE_RIGHT):
        w_hi = (bus.count_val >= w_cmp1);
      (w_mode == MODE_WINDOW):
        w_hi = (bus.count_val >= w_cmp1) &&
               (bus.count_val < w_cmp2);
      (w_mode == MODE_RSVD):
        w_hi = IDLE_LVL;
      default:
        w_hi = IDLE_LVL;
    endcase
  end

  // Registered output, idle when disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pwm_out <= IDLE_LVL;
    else        r_pwm_out <= bus.pwm_en ? w_hi : IDLE_LVL;
  end

  assign bus.pwm_out    = r_pwm_out;
  assign bus.period_evt = w_evt;

endmodule

// File: tb/tb_pwm_gen.sv
// pwm_gen scoreboard bench
// Random and directed stimulus against a rule-level model
module tb_pwm_gen;
  import pwm_pkg::*;

  localparam int   W    = 16;
  localparam logic IDLE = 1'b0;

  typedef struct {
    logic out;
    logic evt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pwm_if #(.CNT_W(W)) bus();

  pwm_gen #(
    .CNT_W   (W),
    .IDLE_LVL(IDLE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int hi_seen = 0;
  int evt_seen = 0;

  logic         s_rst = 1'b0;
  logic         s_en = 1'b0;
  logic [1:0]   s_mode = MODE_LEFT;
  logic [W-1:0] s_c1 = '0;
  logic [W-1:0] s_c2 = '0;
  logic [W-1:0] t_per = '0;
  logic         t_up = 1'b1;
  logic [W-1:0] t_cnt = '0;
  int           step_pct = 100;

  logic [W-1:0] m_prev = '0;
  logic [W-1:0] m_c1 = '0;
  logic [W-1:0] m_c2 = '0;
  logic [W-1:0] m_per = '0;
  logic [1:0]   m_mode = '0;

  task automatic chk(string nm, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic cycle();
    exp_t e;
    logic tk, bd, hi;
    @(negedge clk);
    if (!s_rst) t_cnt = '0;
    else if ($urandom_range(99) < step_pct) begin
      if (t_up)
        t_cnt = (t_cnt >= t_per) ? '0 : t_cnt + 1'b1;
      else
        t_cnt = (t_cnt == '0) ? t_per : t_cnt - 1'b1;
    end
    rst_n         = s_rst;
    bus.count_val = t_cnt;
    bus.period    = t_per;
    bus.upnotdown = t_up;
    bus.pwm_en    = s_en;
    bus.functions = s_mode;
    bus.compare1  = s_c1;
    bus.compare2  = s_c2;
    if (!s_rst) begin
      m_prev = '0; m_c1 = '0; m_c2 = '0;
      m_per = '0; m_mode = '0;
      e.out = IDLE; e.evt = 1'b0;
    end else begin
      tk = (t_cnt != m_prev);
      bd = tk && (t_up ? (t_cnt == 0) : (t_cnt == m_per));
      if (!s_en || bd) begin
        m_c1 = s_c1; m_c2 = s_c2;
        m_per = t_per; m_mode = s_mode;
      end
      case (m_mode)
        2'd0:    hi = t_cnt < m_c1;
        2'd1:    hi = t_cnt >= m_c1;
        2'd2:    hi = (t_cnt >= m_c1) && (t_cnt < m_c2);
        default: hi = IDLE;
      endcase
      e.out = s_en ? hi : IDLE;
      e.evt = bd && s_en;
      m_prev = t_cnt;
    end
    q.push_back(e);
    if (!s_rst) begin
      #1;
      chk("async_rst_out", bus.pwm_out, IDLE);
      chk("async_rst_evt", bus.period_evt, 1'b0);
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic reprogram();
    s_en = 1'b0;
    cycle();
    s_en = 1'b1;
  endtask

  task automatic wait_cnt(logic [W-1:0] v);
    int k;
    k = 0;
    while (t_cnt != v && k < 200) begin
      cycle();
      k++;
    end
    chk_int("wait_cnt_timeout", int'(t_cnt), int'(v));
  endtask

  task automatic window_hi(string nm, int n, int hi, int ev);
    int h0, e0;
    h0 = hi_seen;
    e0 = evt_seen;
    run(n);
    @(posedge clk);
    #2;
    chk_int({nm, "_hi"}, hi_seen - h0 - int'(bus.pwm_out), hi);
    chk_int({nm, "_evt"},
            evt_seen - e0 - int'(bus.period_evt), ev);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pwm_out", bus.pwm_out, e.out);
      chk("period_evt", bus.period_evt, e.evt);
      hi_seen  += int'(bus.pwm_out);
      evt_seen += int'(bus.period_evt);
    end
  end

  initial begin
    rst_n = 1'b0;
    run(3);
    s_rst = 1'b1;

    t_per = 9; t_up = 1'b1;
    s_mode = MODE_LEFT; s_c1 = 3;
    reprogram();
    run(12);
    window_hi("left", 30, 9, 3);

    s_mode = MODE_RIGHT;
    reprogram();
    run(12);
    wait_cnt(5);
    s_c1 = 6;
    run(25);
    window_hi("right6", 30, 12, 3);

    t_per = 7; s_mode = MODE_WINDOW;
    s_c1 = 2; s_c2 = 5;
    reprogram();
    run(16);
    window_hi("window", 32, 12, 4);
    s_c2 = 2;
    run(10);
    window_hi("win_empty", 24, 0, 3);

    t_per = 4; t_up = 1'b0;
    s_mode = MODE_LEFT; s_c1 = 5;
    reprogram();
    run(12);
    window_hi("down_hi", 20, 20, 4);

    t_up = 1'b1; t_per = 9; s_c1 = 0;
    reprogram();
    run(12);
    window_hi("cmp0", 20, 0, 2);
    s_mode = MODE_RSVD;
    reprogram();
    window_hi("rsvd", 20, 0, 2);
    s_mode = MODE_LEFT; s_c1 = 3;
    reprogram();
    run(14);
    s_en = 1'b0;
    window_hi("en_low", 20, 0, 0);

    s_mode = MODE_RIGHT; s_c1 = 0;
    s_en = 1'b1;
    run(7);
    s_rst = 1'b0; s_en = 1'b0;
    run(2);
    s_rst = 1'b1;
    cycle();
    s_en = 1'b1;
    run(20);

    step_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 4)
        t_per = W'($urandom_range(12));
      if ($urandom_range(99) < 8)
        s_c1 = W'($urandom_range(14));
      if ($urandom_range(99) < 8)
        s_c2 = W'($urandom_range(14));
      if ($urandom_range(99) < 3)
        s_mode = 2'($urandom_range(3));
      if ($urandom_range(99) < 2) t_up = ~t_up;
      if ($urandom_range(99) < 3) s_en = ~s_en;
      if ($urandom_range(99) < 2) t_cnt = '0;
      s_rst = ($urandom_range(199) != 0);
      cycle();
    end
    s_rst = 1'b1;
    run(4);
    @(posedge clk);
    #3;
    chk_int("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
